// File: rtl/viterbi_sched.sv
// Viterbi back-end sequencer: survivor bank rotation, traceback routing and
// ping-pong display addressing. All memory-facing controls are registered.

module viterbi_sched_slot #(
  parameter int          ADDR_W = 10,
  parameter int unsigned IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        bank,
  input  logic [ADDR_W-1:0] wr_cnt,
  input  logic [ADDR_W-1:0] rd_cnt,
  output logic              wr,
  output logic [ADDR_W-1:0] addr
);
  // Role of this bank relative to the current write bank:
  // 0 = write, 1/3 = traceback read, 2 = idle.
  logic [1:0] off;
  assign off = 2'(IDX) - bank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr   <= 1'b0;
      addr <= '0;
    end else if (!enable) begin
      wr   <= 1'b0;
      addr <= '0;
    end else begin
      case (off)
        2'd0:    begin wr <= 1'b1; addr <= wr_cnt; end
        2'd2:    begin wr <= 1'b0; addr <= '0;     end
        default: begin wr <= 1'b0; addr <= rd_cnt; end
      endcase
    end
  end
endmodule

module viterbi_sched #(
  parameter int ADDR_W = 10,
  parameter int TB_DLY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [3:0]          wr_bank,
  output logic [4*ADDR_W-1:0] addr_bank,
  output logic [1:0]          tb_route,
  output logic                tbu0_en,
  output logic                tbu1_en,
  output logic                tbu0_sel,
  output logic                tbu1_sel,
  output logic [ADDR_W-1:0]   disp_addr0,
  output logic [ADDR_W-1:0]   disp_addr1,
  output logic                out_sel,
  output logic                busy,
  output logic                out_valid
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  localparam logic [ADDR_W-1:0] DWR_INIT = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] DRD_INIT = {ADDR_W{1'b1}} - ADDR_W'(2);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      wr_cnt, rd_cnt;
  logic [1:0]             bank;
  logic                   wrap;
  logic [TB_DLY:1][1:0]   route_pipe;
  logic [ADDR_W-1:0]      dwr_cnt, drd_cnt;
  logic                   dsel, dsel_d1;

  assign wrap     = &wr_cnt;
  assign busy     = (state != IDLE);
  assign tb_route = route_pipe[TB_DLY];
  assign tbu1_sel = ~tbu0_sel;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = FILL;
        FILL:    if (wrap && bank == 2'd1) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------- write/read counters and bank rotation ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt <= '0;
      rd_cnt <= '1;
      bank   <= 2'd0;
    end else if (!enable) begin
      wr_cnt <= '0;
      rd_cnt <= '1;
      bank   <= 2'd0;
    end else begin
      wr_cnt <= wr_cnt + 1'b1;
      rd_cnt <= rd_cnt - 1'b1;
      if (wrap) bank <= bank + 2'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    viterbi_sched_slot #(.ADDR_W(ADDR_W), .IDX(g)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .bank   (bank),
      .wr_cnt (wr_cnt),
      .rd_cnt (rd_cnt),
      .wr     (wr_bank[g]),
      .addr   (addr_bank[g*ADDR_W +: ADDR_W])
    );
  end

  // ---------------- traceback routing ----------------
  // Bank index delayed by the survivor read latency before it steers the TBUs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      route_pipe <= '0;
      tbu0_sel   <= 1'b0;
      tbu0_en    <= 1'b0;
      tbu1_en    <= 1'b0;
    end else if (!enable) begin
      route_pipe <= '0;
      tbu0_sel   <= 1'b0;
      tbu0_en    <= 1'b0;
      tbu1_en    <= 1'b0;
    end else begin
      route_pipe[1] <= bank;
      for (int i = 2; i <= TB_DLY; i++) route_pipe[i] <= route_pipe[i-1];
      tbu0_sel <= tb_route[0];
      if (tb_route == 2'd2) tbu0_en <= 1'b1;
      if (tb_route == 2'd3) tbu1_en <= 1'b1;
    end
  end

  // ---------------- display ping-pong ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwr_cnt    <= DWR_INIT;
      drd_cnt    <= DRD_INIT;
      dsel       <= 1'b0;
      dsel_d1    <= 1'b0;
      out_sel    <= 1'b0;
      disp_addr0 <= '0;
      disp_addr1 <= '0;
      out_valid  <= 1'b0;
    end else if (!enable) begin
      dwr_cnt    <= DWR_INIT;
      drd_cnt    <= DRD_INIT;
      dsel       <= 1'b0;
      dsel_d1    <= 1'b0;
      out_sel    <= 1'b0;
      disp_addr0 <= '0;
      disp_addr1 <= '0;
      out_valid  <= 1'b0;
    end else begin
      dwr_cnt    <= dwr_cnt - 1'b1;
      drd_cnt    <= drd_cnt + 1'b1;
      dsel       <= tb_route[0];
      dsel_d1    <= dsel;
      out_sel    <= dsel_d1;
      disp_addr0 <= dsel ? dwr_cnt : drd_cnt;
      disp_addr1 <= dsel ? drd_cnt : dwr_cnt;
      // First out_sel flip after TBU0 is live marks the first valid bit.
      if (tbu0_en && (dsel_d1 != out_sel)) out_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_viterbi_sched.sv
// Directed + randomized bench for viterbi_sched; expectations derived from the
// number of enabled edges since the last restart.

module tb_viterbi_sched;
  localparam int AW  = 3;
  localparam int DLY = 2;
  localparam int D   = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [3:0]        wr_bank;
  logic [4*AW-1:0]   addr_bank;
  logic [1:0]        tb_route;
  logic              tbu0_en, tbu1_en, tbu0_sel, tbu1_sel;
  logic [AW-1:0]     disp_addr0, disp_addr1;
  logic              out_sel, busy, out_valid;

  int n_cmp = 0;
  int n_err = 0;
  int n     = 0;   // enabled edges since last restart

  viterbi_sched #(.ADDR_W(AW), .TB_DLY(DLY)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wr_bank(wr_bank), .addr_bank(addr_bank), .tb_route(tb_route),
    .tbu0_en(tbu0_en), .tbu1_en(tbu1_en), .tbu0_sel(tbu0_sel), .tbu1_sel(tbu1_sel),
    .disp_addr0(disp_addr0), .disp_addr1(disp_addr1),
    .out_sel(out_sel), .busy(busy), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: functions of edge count k ----------------
  function automatic int bank_at(int k);
    return (k <= 0) ? 0 : (k / D) % 4;
  endfunction
  function automatic int route_at(int k);
    return bank_at(k - DLY);
  endfunction
  function automatic int sel_at(int k);
    return (k < 1) ? 0 : route_at(k - 1) % 2;
  endfunction
  function automatic int osel_at(int k);
    return sel_at(k - 2);
  endfunction
  function automatic int dwc_at(int k);
    return (((2 - k) % D) + D) % D;
  endfunction
  function automatic int drc_at(int k);
    return (D - 3 + k) % D;
  endfunction
  function automatic int en_at(int k, int r);
    for (int m = 0; m < k; m++) if (route_at(m) == r) return 1;
    return 0;
  endfunction
  function automatic int ov_at(int k);
    for (int m = 1; m <= k; m++)
      if (osel_at(m) != osel_at(m - 1) && en_at(m - 1, 2) == 1) return 1;
    return 0;
  endfunction
  function automatic int da_at(int k, int which);
    if (k < 1) return 0;
    if ((sel_at(k - 1) == 1) ^ (which == 1)) return dwc_at(k - 1);
    return drc_at(k - 1);
  endfunction
  function automatic logic [4*AW-1:0] addr_at(int k);
    logic [4*AW-1:0] r;
    int b, w;
    r = '0;
    if (k >= 1) begin
      b = bank_at(k - 1);
      w = (k - 1) % D;
      r[b*AW +: AW]             = AW'(w);
      r[((b + 1) % 4)*AW +: AW] = AW'(D - 1 - w);
      r[((b + 3) % 4)*AW +: AW] = AW'(D - 1 - w);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s n=%0d got %0h exp %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("wr_bank",    64'(wr_bank),    (n >= 1) ? 64'(1 << bank_at(n - 1)) : 64'd0);
    chk("addr_bank",  64'(addr_bank),  64'(addr_at(n)));
    chk("tb_route",   64'(tb_route),   64'(route_at(n)));
    chk("tbu0_en",    64'(tbu0_en),    64'(en_at(n, 2)));
    chk("tbu1_en",    64'(tbu1_en),    64'(en_at(n, 3)));
    chk("tbu0_sel",   64'(tbu0_sel),   64'(sel_at(n)));
    chk("tbu1_sel",   64'(tbu1_sel),   64'(1 - sel_at(n)));
    chk("disp_addr0", 64'(disp_addr0), 64'(da_at(n, 0)));
    chk("disp_addr1", 64'(disp_addr1), 64'(da_at(n, 1)));
    chk("out_sel",    64'(out_sel),    64'(osel_at(n)));
    chk("busy",       64'(busy),       64'(n >= 1));
    chk("out_valid",  64'(out_valid),  64'(ov_at(n)));
  endtask

  // Drive enable away from the edge, step one clock, check at the falling edge.
  task automatic tick(input logic en);
    enable = en;
    @(posedge clk);
    n = en ? n + 1 : 0;
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    n = 0;
    check_all();
    #1 rst = 1'b1;
  endtask

  initial begin
    // Power-on reset held across edges with enable high: outputs stay cleared.
    enable = 1'b1;
    #12;
    n = 0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    tick(1'b0);

    // Fill, rotation through all four banks, TBU enables and display swaps.
    for (int i = 0; i < 40; i++) tick(1'b1);

    // Restart mid-bank at edge 20, then rerun past the first output.
    tick(1'b0);
    for (int i = 0; i < 19; i++) tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1);

    // Asynchronous reset between edges while running.
    async_reset();
    for (int i = 0; i < 25; i++) tick(1'b1);

    // Long randomized run with occasional restarts and async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick(($urandom_range(0, 59) != 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
